// File: rtl/event_dispatch_sched.sv
// Event dispatcher: coalesces trigger pulses into a pending vector and hands them one at a time
// to a valid/ready consumer. Define EVENT_SCHED_STRICT_ORDER_EN for strict 0..N-1 ordering instead of round-robin.
module event_dispatch_sched #(
  parameter int N     = 100,
  parameter int IDX_W = $clog2(N),
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     trig_i,
  output logic             out_valid_o,
  output logic [IDX_W-1:0] out_idx_o,
  input  logic             out_ready_i,
  output logic [N-1:0]     triggered_o,
  output logic [N-1:0]     pending_o,
  output logic [7:0]       drop_cnt_o,
  output logic [CNT_W-1:0] disp_cnt_o
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [0:0]       state;
  logic [N-1:0]     pending;
  logic             hs;
  logic             found;
  logic             load;
  logic [IDX_W-1:0] sel;
  logic [N-1:0]     clr;
  logic [N-1:0]     held;
  logic [N-1:0]     drop_vec;
  logic [15:0]      drop_sum;
  logic [7:0]       drop_nxt;

  assign hs          = (state == HOLD) && out_ready_i;
  assign out_valid_o = (state == HOLD);
  assign pending_o   = pending;

`ifdef EVENT_SCHED_STRICT_ORDER_EN
  logic [IDX_W-1:0] next_idx;
  logic [IDX_W-1:0] next_inc;
  logic [IDX_W-1:0] cand;

  assign next_inc = (next_idx == IDX_W'(N - 1)) ? '0 : next_idx + 1'b1;
  // After a handshake the next turn belongs to the following index.
  assign cand     = hs ? next_inc : next_idx;
  assign found    = pending[cand];
  assign sel      = cand;
`else
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] base;

  // A handshake this cycle moves the pointer to out_idx_o, so search from there.
  assign base = hs ? out_idx_o : rr_ptr;

  always_comb begin
    int j;
    found = 1'b0;
    sel   = '0;
    j     = 0;
    // Descending scan so the nearest index after base wins.
    for (int i = N; i >= 1; i--) begin
      j = int'(base) + i;
      if (j >= N) j = j - N;
      if (pending[j]) begin
        found = 1'b1;
        sel   = IDX_W'(j);
      end
    end
  end
`endif

  assign load = found && ((state == IDLE) || hs);

  always_comb begin
    clr  = '0;
    held = '0;
    if (load) clr[sel] = 1'b1;
    if (state == HOLD) held[out_idx_o] = 1'b1;
  end

  // Set beats clear; the index being offered is never counted as a drop.
  assign drop_vec = trig_i & pending & ~clr & ~held;

  always_comb begin
    drop_sum = 16'(drop_cnt_o);
    for (int k = 0; k < N; k++) drop_sum = drop_sum + 16'(drop_vec[k]);
    drop_nxt = (drop_sum > 16'd255) ? 8'd255 : drop_sum[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pending     <= '0;
      out_idx_o   <= '0;
      triggered_o <= '0;
      drop_cnt_o  <= '0;
      disp_cnt_o  <= '0;
`ifdef EVENT_SCHED_STRICT_ORDER_EN
      next_idx    <= '0;
`else
      rr_ptr      <= IDX_W'(N - 1);
`endif
    end else begin
      pending     <= (pending & ~clr) | trig_i;
      triggered_o <= trig_i;
      drop_cnt_o  <= drop_nxt;
      if (hs) begin
        disp_cnt_o <= disp_cnt_o + 1'b1;
`ifdef EVENT_SCHED_STRICT_ORDER_EN
        next_idx   <= next_inc;
`else
        rr_ptr     <= out_idx_o;
`endif
      end
      if (load) begin
        out_idx_o <= sel;
        state     <= HOLD;
      end else if (hs) begin
        state     <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_event_dispatch_sched.sv
// Directed bench for event_dispatch_sched: N=4 round-robin scenarios by default,
// N=100 strict-order scenario when EVENT_SCHED_STRICT_ORDER_EN is defined.
module tb_event_dispatch_sched;
`ifdef EVENT_SCHED_STRICT_ORDER_EN
  localparam int N = 100;
`else
  localparam int N = 4;
`endif
  localparam int IDX_W = $clog2(N);
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             out_ready = 1'b0;
  logic [N-1:0]     trig = '0;
  logic             out_valid;
  logic [IDX_W-1:0] out_idx;
  logic [N-1:0]     triggered;
  logic [N-1:0]     pending;
  logic [7:0]       drop_cnt;
  logic [CNT_W-1:0] disp_cnt;

  int checks = 0;
  int errors = 0;
  int exp_disp = 0;

  always #5 clk = ~clk;

  event_dispatch_sched #(.N(N), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .trig_i(trig), .out_valid_o(out_valid), .out_idx_o(out_idx),
    .out_ready_i(out_ready), .triggered_o(triggered), .pending_o(pending),
    .drop_cnt_o(drop_cnt), .disp_cnt_o(disp_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    trig = '0;
    #1 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", out_valid); end
    checks++; if (pending !== '0) begin errors++; $display("FAIL reset_pending got %0h exp 0", pending); end
    checks++; if (disp_cnt !== '0 || drop_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt got disp %0d drop %0d exp 0 0", disp_cnt, drop_cnt); end
    step(); step();
    rst = 1'b0;
    step();
  endtask

`ifndef EVENT_SCHED_STRICT_ORDER_EN
  task automatic test_rr_wrap();
    out_ready = 1'b1;
    trig = 4'b1111;
    step();
    trig = 4'b0000;
    checks++; if (out_valid !== 1'b0 || pending !== 4'b1111) begin errors++; $display("FAIL rr_arm got v %0b p %b exp v 0 p 1111", out_valid, pending); end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (out_valid !== 1'b1 || out_idx !== IDX_W'(i)) begin errors++; $display("FAIL rr_seq%0d got v %0b idx %0d exp v 1 idx %0d", i, out_valid, out_idx, i); end
    end
    step();
    exp_disp = 4;
    checks++; if (out_valid !== 1'b0 || disp_cnt !== 32'(exp_disp)) begin errors++; $display("FAIL rr_done got v %0b disp %0d exp v 0 disp %0d", out_valid, disp_cnt, exp_disp); end
    trig = 4'b0011;
    step();
    trig = 4'b0000;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (out_valid !== 1'b1 || out_idx !== IDX_W'(i)) begin errors++; $display("FAIL rr_wrap%0d got v %0b idx %0d exp v 1 idx %0d", i, out_valid, out_idx, i); end
    end
    step();
    exp_disp = 6;
    checks++; if (out_valid !== 1'b0 || disp_cnt !== 32'(exp_disp)) begin errors++; $display("FAIL rr_wrap_done got v %0b disp %0d exp v 0 disp %0d", out_valid, disp_cnt, exp_disp); end
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    trig = 4'b0100;
    step();
    trig = 4'b0000;
    checks++; if (triggered !== 4'b0100 || out_valid !== 1'b0) begin errors++; $display("FAIL single_cyc1 got trg %b v %0b exp trg 0100 v 0", triggered, out_valid); end
    step();
    checks++; if (out_valid !== 1'b1 || out_idx !== 2'd2 || triggered !== 4'b0000) begin errors++; $display("FAIL single_cyc2 got v %0b idx %0d trg %b exp v 1 idx 2 trg 0000", out_valid, out_idx, triggered); end
    step();
    exp_disp++;
    checks++; if (out_valid !== 1'b0 || disp_cnt !== 32'(exp_disp)) begin errors++; $display("FAIL single_cyc3 got v %0b disp %0d exp v 0 disp %0d", out_valid, disp_cnt, exp_disp); end
  endtask

  task automatic test_coalesce();
    out_ready = 1'b0;
    trig = 4'b0001;
    step();
    trig = 4'b0000;
    step();
    checks++; if (out_valid !== 1'b1 || out_idx !== 2'd0) begin errors++; $display("FAIL coal_hold got v %0b idx %0d exp v 1 idx 0", out_valid, out_idx); end
    for (int i = 0; i < 3; i++) begin
      trig = 4'b0010;
      step();
      trig = 4'b0000;
      step();
    end
    checks++; if (drop_cnt !== 8'd2 || out_idx !== 2'd0 || pending !== 4'b0010) begin errors++; $display("FAIL coal_drop got drop %0d idx %0d p %b exp drop 2 idx 0 p 0010", drop_cnt, out_idx, pending); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    exp_disp++;
    checks++; if (out_valid !== 1'b1 || out_idx !== 2'd1 || pending !== 4'b0000) begin errors++; $display("FAIL coal_reload got v %0b idx %0d p %b exp v 1 idx 1 p 0000", out_valid, out_idx, pending); end
    trig = 4'b0010;
    step();
    step();
    trig = 4'b0000;
    checks++; if (drop_cnt !== 8'd2 || pending !== 4'b0010) begin errors++; $display("FAIL coal_held_nodrop got drop %0d p %b exp drop 2 p 0010", drop_cnt, pending); end
    out_ready = 1'b1;
    step();
    exp_disp++;
    checks++; if (out_valid !== 1'b1 || out_idx !== 2'd1 || disp_cnt !== 32'(exp_disp)) begin errors++; $display("FAIL coal_redisp got v %0b idx %0d disp %0d exp v 1 idx 1 disp %0d", out_valid, out_idx, disp_cnt, exp_disp); end
    step();
    exp_disp++;
    checks++; if (out_valid !== 1'b0 || disp_cnt !== 32'(exp_disp)) begin errors++; $display("FAIL coal_done got v %0b disp %0d exp v 0 disp %0d", out_valid, disp_cnt, exp_disp); end
  endtask

  task automatic test_set_wins();
    out_ready = 1'b0;
    trig = 4'b1000;
    step();
    step();
    trig = 4'b0000;
    checks++; if (out_valid !== 1'b1 || out_idx !== 2'd3 || pending !== 4'b1000 || drop_cnt !== 8'd2) begin errors++; $display("FAIL setwins got v %0b idx %0d p %b drop %0d exp v 1 idx 3 p 1000 drop 2", out_valid, out_idx, pending, drop_cnt); end
    out_ready = 1'b1;
    step();
    exp_disp++;
    checks++; if (out_valid !== 1'b1 || out_idx !== 2'd3 || pending !== 4'b0000) begin errors++; $display("FAIL setwins_again got v %0b idx %0d p %b exp v 1 idx 3 p 0000", out_valid, out_idx, pending); end
    step();
    exp_disp++;
    checks++; if (out_valid !== 1'b0 || disp_cnt !== 32'(exp_disp)) begin errors++; $display("FAIL setwins_done got v %0b disp %0d exp v 0 disp %0d", out_valid, disp_cnt, exp_disp); end
  endtask

  task automatic test_drop_sat();
    out_ready = 1'b0;
    trig = 4'b0011;
    for (int i = 0; i < 300; i++) step();
    trig = 4'b0000;
    checks++; if (drop_cnt !== 8'd255 || out_idx !== 2'd0) begin errors++; $display("FAIL drop_sat got drop %0d idx %0d exp drop 255 idx 0", drop_cnt, out_idx); end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    exp_disp += 3;
    checks++; if (out_valid !== 1'b0 || disp_cnt !== 32'(exp_disp) || drop_cnt !== 8'd255) begin errors++; $display("FAIL drop_drain got v %0b disp %0d drop %0d exp v 0 disp %0d drop 255", out_valid, disp_cnt, drop_cnt, exp_disp); end
  endtask

  task automatic test_reset_mid_hold();
    out_ready = 1'b0;
    trig = 4'b0100;
    step();
    trig = 4'b0001;
    step();
    trig = 4'b0000;
    checks++; if (out_valid !== 1'b1 || out_idx !== 2'd2 || pending !== 4'b0001) begin errors++; $display("FAIL midrst_pre got v %0b idx %0d p %b exp v 1 idx 2 p 0001", out_valid, out_idx, pending); end
    #2 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || out_idx !== 2'd0 || pending !== 4'b0000) begin errors++; $display("FAIL midrst_state got v %0b idx %0d p %b exp v 0 idx 0 p 0000", out_valid, out_idx, pending); end
    checks++; if (disp_cnt !== '0 || drop_cnt !== 8'd0 || triggered !== 4'b0000) begin errors++; $display("FAIL midrst_cnt got disp %0d drop %0d trg %b exp 0 0 0000", disp_cnt, drop_cnt, triggered); end
    step();
    rst = 1'b0;
    step();
  endtask
`else
  task automatic test_strict_order();
    int got;
    out_ready = 1'b1;
    for (int k = N - 1; k >= 0; k--) begin
      trig = '0;
      trig[k] = 1'b1;
      step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL strict_early k=%0d got v %0b exp v 0", k, out_valid); end
    end
    trig = '0;
    got = 0;
    for (int c = 0; c < 300 && got < N; c++) begin
      step();
      if (out_valid) begin
        checks++; if (out_idx !== IDX_W'(got)) begin errors++; $display("FAIL strict_order got idx %0d exp %0d", out_idx, got); end
        got++;
      end
    end
    checks++; if (got != N) begin errors++; $display("FAIL strict_count got %0d dispatches exp %0d", got, N); end
    step();
    checks++; if (out_valid !== 1'b0 || disp_cnt !== 32'd100) begin errors++; $display("FAIL strict_done got v %0b disp %0d exp v 0 disp 100", out_valid, disp_cnt); end
    trig = '0;
    trig[0] = 1'b1;
    step();
    trig = '0;
    step();
    checks++; if (out_valid !== 1'b1 || out_idx !== '0) begin errors++; $display("FAIL strict_wrap got v %0b idx %0d exp v 1 idx 0", out_valid, out_idx); end
    step();
    checks++; if (out_valid !== 1'b0 || disp_cnt !== 32'd101) begin errors++; $display("FAIL strict_wrap_done got v %0b disp %0d exp v 0 disp 101", out_valid, disp_cnt); end
  endtask
`endif

  initial begin
    test_reset();
`ifndef EVENT_SCHED_STRICT_ORDER_EN
    test_rr_wrap();
    test_single();
    test_coalesce();
    test_set_wins();
    test_drop_sat();
    test_reset_mid_hold();
`else
    test_strict_order();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
